// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, port identifiers and default memory size.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int MEM_BYTES_DEF = 1024;

endpackage

// File: rtl/dmem_addr_check.sv
// Address validity check for the data memory.
// Flags misaligned words and words that run past the end of memory.
module dmem_addr_check
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic [31:0] i_addr,
    output logic        o_err
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    assign o_err = (i_addr[1:0] != 2'b00) || (i_addr > LAST_WORD);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline port A, loader/debug port B.
// One request at a time through IDLE -> ACCESS -> RESP.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES    = MEM_BYTES_DEF,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_starve;
    logic          r_we;
    logic          r_port;
    logic          r_err;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;

    logic        w_any;
    logic        w_grant_b;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_addr_err;
    logic        w_access;
    logic        w_resp;

    assign w_any       = a_req | b_req;
    // B wins when alone, or when A has starved it STARVE_LIMIT times
    assign w_grant_b   = b_req & (~a_req | (r_starve == LIMIT));
    assign w_sel_we    = w_grant_b ? b_we    : a_we;
    assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;

    dmem_addr_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .i_addr (w_sel_addr),
        .o_err  (w_addr_err)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any)
                    w_next = w_addr_err ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_starve <= '0;
            r_we     <= 1'b0;
            r_port   <= PORT_A;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_any) begin
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_port  <= w_grant_b;
                r_err   <= w_addr_err;
                r_rdata <= '0;
                if (w_grant_b)
                    r_starve <= '0;
                else if (b_req && r_starve != LIMIT)
                    r_starve <= r_starve + 1'b1;
            end
            if (r_state == ST_ACCESS)
                r_rdata <= r_we ? 32'd0 : mem_rdata;
        end
    end

    assign w_access  = (r_state == ST_ACCESS);
    assign w_resp    = (r_state == ST_RESP);

    assign mem_read  = w_access & ~r_we;
    assign mem_write = w_access & r_we;
    assign mem_addr  = w_access ? r_addr  : 32'd0;
    assign mem_wdata = w_access ? r_wdata : 32'd0;

    assign a_ack   = w_resp & (r_port == PORT_A);
    assign a_err   = a_ack & r_err;
    assign a_rdata = a_ack ? r_rdata : 32'd0;

    assign b_ack   = w_resp & (r_port == PORT_B);
    assign b_err   = b_ack & r_err;
    assign b_rdata = b_ack ? r_rdata : 32'd0;

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    logic [31:0] mem [0:255];

    dmem_arbiter #(
        .MEM_BYTES    (1024),
        .STARVE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write)
            mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack
    always @(negedge clk) begin
        if (rst) begin
            exp_t e;
            if (mem_write) n_wr++;
            if (mem_read)  n_rd++;
            chk("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
            if (!mem_read && !mem_write)
                chk("mem_bus_idle", mem_addr | mem_wdata, 32'd0);
            if (!a_ack) chk("a_quiet", a_rdata | {31'd0, a_err}, 32'd0);
            if (!b_ack) chk("b_quiet", b_rdata | {31'd0, b_err}, 32'd0);
            if (a_ack && b_ack) begin
                chk("dual_ack", 32'd1, 32'd0);
            end else if (a_ack || b_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {31'd0, b_ack}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", {31'd0, b_ack}, {31'd0, e.port});
                    chk("ack_rdata", b_ack ? b_rdata : a_rdata, e.rdata);
                    chk("ack_err", {31'd0, b_ack ? b_err : a_err},
                        {31'd0, e.err});
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input bit port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // Issue from an idle DUT at a negedge; n > 1 keeps req held across acks
    task automatic issue(input bit port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit xerr, input logic [31:0] xrdata,
                         input int n);
        int   base;
        int   gap;
        int   lat;
        int   last;
        exp_t e;
        base = cyc + 1;
        gap  = xerr ? 2 : 3;
        lat  = xerr ? 0 : 1;
        for (int i = 0; i < n; i++) begin
            e.port  = port;
            e.rdata = xrdata;
            e.err   = xerr;
            e.cyc   = base + lat + gap * i;
            sb.push_back(e);
        end
        last = base + lat + gap * (n - 1);
        drive(port, 1'b1, we, addr, wdata);
        while (cyc < last) @(negedge clk);
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int   wr0;
        int   rd0;
        int   base;
        bit   order [8];
        exp_t e;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rst = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;

        #3;
        chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
        chk("rst_b_ack", {31'd0, b_ack}, 32'd0);
        chk("rst_errs", {30'd0, a_err, b_err}, 32'd0);
        chk("rst_rdata", a_rdata | b_rdata, 32'd0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_bus", mem_addr | mem_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Write then read back on port A
        wr0 = n_wr;
        issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 1);
        chk("write_one_cycle", n_wr - wr0, 1);
        rd0 = n_rd;
        issue(1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 1);
        chk("read_one_cycle", n_rd - rd0, 1);

        // Misaligned and out-of-range requests never touch memory
        wr0 = n_wr;
        rd0 = n_rd;
        issue(1'b0, 1'b0, 32'h13, 32'd0, 1'b1, 32'd0, 1);
        issue(1'b0, 1'b1, 32'd1021, 32'h5555_5555, 1'b1, 32'd0, 1);
        issue(1'b0, 1'b0, 32'd1024, 32'd0, 1'b1, 32'd0, 1);
        chk("err_no_strobe", (n_wr - wr0) + (n_rd - rd0), 0);

        // Last valid word is in range
        issue(1'b0, 1'b1, 32'd1020, 32'hA5A5_0001, 1'b0, 32'd0, 1);
        chk("last_word_mem", mem[255], 32'hA5A5_0001);

        // Port B alone, then A reads B's data
        issue(1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'd0, 1);
        issue(1'b0, 1'b0, 32'h40, 32'd0, 1'b0, 32'h1234_5678, 1);

        // Continuous contention: A,A,A,B,A,A,A,B
        order = '{0, 0, 0, 1, 0, 0, 0, 1};
        base = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            e.port  = order[i];
            e.rdata = order[i] ? 32'h1234_5678 : 32'hDEAD_BEEF;
            e.err   = 1'b0;
            e.cyc   = base + 1 + 3 * i;
            sb.push_back(e);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
        while (cyc < base + 22) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);

        // Req held through the ack gives a back-to-back second access
        issue(1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 2);

        // Reset mid-ACCESS of a write discards it
        drive(1'b0, 1'b1, 1'b1, 32'h80, 32'hCAFE_F00D);
        @(negedge clk);
        chk("access_write", {31'd0, mem_write}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_write_drop", {31'd0, mem_write}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_mem_bus", mem_addr | mem_wdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("aborted_mem", mem[32], 32'd0);
        issue(1'b0, 1'b0, 32'h80, 32'd0, 1'b0, 32'd0, 1);

        repeat (4) @(negedge clk);
        chk("pending_acks", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
